// File: rtl/clock_pkg.sv
// Shared definitions for the digital clock: mode encoding, field widths and limits,
// and modulo-increment helpers for the hour and minute/second fields.
package clock_pkg;

  localparam int unsigned HR_W = 5;
  localparam int unsigned MS_W = 6;

  localparam logic [HR_W-1:0] HOURS_MAX   = 5'd23;
  localparam logic [MS_W-1:0] MIN_SEC_MAX = 6'd59;

  typedef enum logic [2:0] {
    MODE_RUN      = 3'd0,
    MODE_SET_HR   = 3'd1,
    MODE_SET_MIN  = 3'd2,
    MODE_SET_AHR  = 3'd3,
    MODE_SET_AMIN = 3'd4
  } mode_e;

  function automatic logic [HR_W-1:0] inc_hours(input logic [HR_W-1:0] v);
    return (v >= HOURS_MAX) ? '0 : v + 5'd1;
  endfunction

  function automatic logic [MS_W-1:0] inc_ms(input logic [MS_W-1:0] v);
    return (v >= MIN_SEC_MAX) ? '0 : v + 6'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter, and a one-cycle
// pulse when the accepted (stable) level rises. Releases produce no pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_press
);

  logic             r_s1;
  logic             r_s2;
  logic             r_stable;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;
  logic             w_done;

  assign w_done = (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_stable <= 1'b0;
      r_press  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_s1    <= i_btn;
      r_s2    <= r_s1;
      r_press <= 1'b0;
      if (r_s2 == r_stable) begin
        r_cnt <= '0;
      end else if (w_done) begin
        // Pulse coincides with the first cycle the stable level reads 1.
        r_stable <= r_s2;
        r_press  <= r_s2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/clock_time_ctrl.sv
// Timekeeping and mode controller: HH:MM:SS counting off a 1 Hz input, button-driven
// set modes and a blink qualifier. Define ALARM_EN to add the alarm fields and states.
module clock_time_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_1Hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [2:0] mode,
  output logic       blink,
  output logic       sec_tick,
  output logic [4:0] alarm_hours,
  output logic [5:0] alarm_minutes,
  output logic       alarm
);

  logic       r_tick_s1;
  logic       r_tick_s2;
  logic       r_tick_hist;
  logic       r_sec_tick;
  logic       r_blink;
  mode_e      r_state;
  mode_e      w_state_nx;
  logic [4:0] r_hours;
  logic [4:0] w_hours_nx;
  logic [5:0] r_minutes;
  logic [5:0] w_min_nx;
  logic [5:0] r_seconds;
  logic [5:0] w_sec_nx;
  logic       w_mode_press;
  logic       w_inc_press;
  logic       w_inc_eff;
  logic       w_leave_set;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_mode (
    .clk    (clk),
    .rst    (rst),
    .i_btn  (btn_mode),
    .o_press(w_mode_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_inc (
    .clk    (clk),
    .rst    (rst),
    .i_btn  (btn_inc),
    .o_press(w_inc_press)
  );

  // A simultaneous mode press swallows the increment.
  assign w_inc_eff = w_inc_press & ~w_mode_press;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_s1   <= 1'b0;
      r_tick_s2   <= 1'b0;
      r_tick_hist <= 1'b0;
      r_sec_tick  <= 1'b0;
      r_blink     <= 1'b0;
    end else begin
      r_tick_s1   <= clk_1Hz;
      r_tick_s2   <= r_tick_s1;
      r_tick_hist <= r_tick_s2;
      r_sec_tick  <= r_tick_s2 & ~r_tick_hist;
      r_blink     <= (r_state != MODE_RUN) & r_tick_s2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= MODE_RUN;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    if (w_mode_press) begin
      unique case (r_state)
        MODE_RUN:      w_state_nx = MODE_SET_HR;
        MODE_SET_HR:   w_state_nx = MODE_SET_MIN;
`ifdef ALARM_EN
        MODE_SET_MIN:  w_state_nx = MODE_SET_AHR;
        MODE_SET_AHR:  w_state_nx = MODE_SET_AMIN;
        MODE_SET_AMIN: w_state_nx = MODE_RUN;
`else
        MODE_SET_MIN:  w_state_nx = MODE_RUN;
`endif
        default:       w_state_nx = MODE_RUN;
      endcase
    end
  end

  assign w_leave_set = w_mode_press && (r_state != MODE_RUN) && (w_state_nx == MODE_RUN);

  always_comb begin
    w_hours_nx = r_hours;
    w_min_nx   = r_minutes;
    w_sec_nx   = r_seconds;
    unique case (r_state)
      MODE_RUN: begin
        if (r_sec_tick) begin
          w_sec_nx = inc_ms(r_seconds);
          if (r_seconds == MIN_SEC_MAX) begin
            w_min_nx = inc_ms(r_minutes);
            if (r_minutes == MIN_SEC_MAX) w_hours_nx = inc_hours(r_hours);
          end
        end
      end
      MODE_SET_HR:  if (w_inc_eff) w_hours_nx = inc_hours(r_hours);
      MODE_SET_MIN: if (w_inc_eff) w_min_nx = inc_ms(r_minutes);
      default: ;
    endcase
    // Returning to RUN restarts the minute; any coincident tick is lost.
    if (w_leave_set) w_sec_nx = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hours   <= '0;
      r_minutes <= '0;
      r_seconds <= '0;
    end else begin
      r_hours   <= w_hours_nx;
      r_minutes <= w_min_nx;
      r_seconds <= w_sec_nx;
    end
  end

`ifdef ALARM_EN
  logic [4:0] r_ahr;
  logic [4:0] w_ahr_nx;
  logic [5:0] r_amin;
  logic [5:0] w_amin_nx;
  logic       r_silence;
  logic       w_silence_nx;
  logic       r_alarm;

  always_comb begin
    w_ahr_nx     = r_ahr;
    w_amin_nx    = r_amin;
    w_silence_nx = r_silence;
    if (w_inc_eff && (r_state == MODE_SET_AHR))  w_ahr_nx  = inc_hours(r_ahr);
    if (w_inc_eff && (r_state == MODE_SET_AMIN)) w_amin_nx = inc_ms(r_amin);
    if (w_min_nx != r_minutes)                              w_silence_nx = 1'b0;
    else if (w_inc_eff && (r_state == MODE_RUN) && r_alarm) w_silence_nx = 1'b1;
  end

  // Alarm is registered from next-state values so it tracks the time registers
  // without lag while still reading 0 during reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ahr     <= '0;
      r_amin    <= '0;
      r_silence <= 1'b0;
      r_alarm   <= 1'b0;
    end else begin
      r_ahr     <= w_ahr_nx;
      r_amin    <= w_amin_nx;
      r_silence <= w_silence_nx;
      r_alarm   <= (w_state_nx == MODE_RUN) && (w_hours_nx == w_ahr_nx) &&
                   (w_min_nx == w_amin_nx) && !w_silence_nx;
    end
  end

  assign alarm_hours   = r_ahr;
  assign alarm_minutes = r_amin;
  assign alarm         = r_alarm;
`else
  assign alarm_hours   = '0;
  assign alarm_minutes = '0;
  assign alarm         = 1'b0;
`endif

  assign hours    = r_hours;
  assign minutes  = r_minutes;
  assign seconds  = r_seconds;
  assign mode     = r_state;
  assign blink    = r_blink;
  assign sec_tick = r_sec_tick;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Self-checking bench for clock_time_ctrl: randomized button/tick stimulus compared
// against a seconds-of-day reference model. Alarm scenario runs when ALARM_EN is defined.
module tb_clock_time_ctrl;

  localparam int unsigned D = 8;
`ifdef ALARM_EN
  localparam int NMODES = 5;
`else
  localparam int NMODES = 3;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_1Hz;
  logic       btn_mode;
  logic       btn_inc;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [2:0] mode;
  logic       blink;
  logic       sec_tick;
  logic [4:0] alarm_hours;
  logic [5:0] alarm_minutes;
  logic       alarm;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: time as seconds of day, mode as position in the press cycle.
  int m_sod, m_mode, m_ahr, m_amin;
  bit m_sil;

  clock_time_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clk_1Hz      (clk_1Hz),
    .btn_mode     (btn_mode),
    .btn_inc      (btn_inc),
    .hours        (hours),
    .minutes      (minutes),
    .seconds      (seconds),
    .mode         (mode),
    .blink        (blink),
    .sec_tick     (sec_tick),
    .alarm_hours  (alarm_hours),
    .alarm_minutes(alarm_minutes),
    .alarm        (alarm)
  );

  always #5 clk = ~clk;

  function automatic bit m_alarm();
`ifdef ALARM_EN
    return (m_mode == 0) && (m_sod / 3600 == m_ahr) && ((m_sod / 60) % 60 == m_amin) && !m_sil;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_vec();
    return {5'(m_sod / 3600), 6'((m_sod / 60) % 60), 6'(m_sod % 60), 3'(m_mode),
            5'(m_ahr), 6'(m_amin), m_alarm()};
  endfunction

  function automatic logic [31:0] obs_vec();
    return {hours, minutes, seconds, mode, alarm_hours, alarm_minutes, alarm};
  endfunction

  function automatic void set_sod(input int t);
    if ((t / 60) % 60 != (m_sod / 60) % 60) m_sil = 1'b0;
    m_sod = t;
  endfunction

  function automatic void model_reset();
    m_sod = 0; m_mode = 0; m_ahr = 0; m_amin = 0; m_sil = 1'b0;
  endfunction

  function automatic void model_tick();
    if (m_mode == 0) set_sod((m_sod + 1) % 86400);
  endfunction

  function automatic void model_mode();
    m_mode = (m_mode + 1) % NMODES;
    if (m_mode == 0) set_sod(m_sod - m_sod % 60);
  endfunction

  function automatic void model_inc();
    int h, mi;
    h  = m_sod / 3600;
    mi = (m_sod / 60) % 60;
    case (m_mode)
      0: if (m_alarm()) m_sil = 1'b1;
      1: set_sod(((h + 1) % 24) * 3600 + mi * 60 + m_sod % 60);
      2: set_sod(h * 3600 + ((mi + 1) % 60) * 60 + m_sod % 60);
      3: m_ahr = (m_ahr + 1) % 24;
      4: m_amin = (m_amin + 1) % 60;
      default: ;
    endcase
  endfunction

  function automatic int rhold();
    return int'($urandom_range(D + 8, D + 2));
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
  endtask

  task automatic do_tick();
    @(negedge clk);
    clk_1Hz = 1'b1;
    repeat (6) @(negedge clk);
    clk_1Hz = 1'b0;
    repeat (6) @(negedge clk);
    model_tick();
  endtask

  task automatic do_press(input bit pm, input bit pi, input int hold);
    @(negedge clk);
    btn_mode = pm;
    btn_inc  = pi;
    repeat (hold) @(negedge clk);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (D + 8) @(negedge clk);
    if (pm) model_mode();
    else if (pi) model_inc();
  endtask

  task automatic do_glitch(input bit pm, input int len);
    @(negedge clk);
    if (pm) btn_mode = 1'b1; else btn_inc = 1'b1;
    repeat (len) @(negedge clk);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (D + 8) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; clk_1Hz = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({obs_vec(), blink, sec_tick} !== 34'd0) begin
      n_bad++; $display("FAIL reset_hold: got %h required 0", {obs_vec(), blink, sec_tick});
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (obs_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL reset_release: got %h required %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_tick();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      clk_1Hz = 1'b1;
      for (int k = 0; k < 5; k++) begin
        @(posedge clk);
        #1;
        if (k == 3) model_tick();
        n_cmp++;
        if (sec_tick !== (k == 2)) begin
          n_bad++; $display("FAIL tick_pulse[%0d] k=%0d: got %b required %b", i, k, sec_tick, (k == 2));
        end
        if (k == 2 || k == 3) begin
          n_cmp++;
          if (seconds !== 6'(m_sod % 60)) begin
            n_bad++; $display("FAIL tick_sec[%0d] k=%0d: got %0d required %0d", i, k, seconds, m_sod % 60);
          end
        end
      end
      clk_1Hz = 1'b0;
      repeat (4 + $urandom_range(3)) @(negedge clk);
    end
    n_cmp++;
    if (seconds !== 6'd3) begin
      n_bad++; $display("FAIL tick_three: got %0d required 3", seconds);
    end
  endtask

  task automatic test_debounce();
    apply_reset();
    do_press(1'b1, 1'b0, rhold());
    for (int i = 0; i < 3; i++) begin
      do_glitch(1'b0, int'($urandom_range(D - 2, 1)));
      do_glitch(1'b1, int'($urandom_range(D - 2, 1)));
    end
    do_glitch(1'b0, D - 2);
    n_cmp++;
    if (obs_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL glitch_ignored: got %h required %h", obs_vec(), exp_vec());
    end
    do_press(1'b0, 1'b1, D + 5);
    n_cmp++;
    if (obs_vec() !== exp_vec() || hours !== 5'd1) begin
      n_bad++; $display("FAIL clean_press: got %h required %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    do_press(1'b1, 1'b0, rhold());
    repeat (23) do_press(1'b0, 1'b1, rhold());
    do_press(1'b1, 1'b0, rhold());
    repeat (59) do_press(1'b0, 1'b1, rhold());
    repeat (NMODES - 2) do_press(1'b1, 1'b0, rhold());
    repeat (58) do_tick();
    n_cmp++;
    if (obs_vec() !== exp_vec() || {hours, minutes, seconds} !== {5'd23, 6'd59, 6'd58}) begin
      n_bad++; $display("FAIL wrap_preload: got %h required %h", obs_vec(), exp_vec());
    end
    do_tick();
    n_cmp++;
    if (obs_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL wrap_2359_59: got %h required %h", obs_vec(), exp_vec());
    end
    @(negedge clk);
    clk_1Hz = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (k == 3) model_tick();
      if (k >= 2) begin
        n_cmp++;
        if (obs_vec() !== exp_vec() || sec_tick !== (k == 2)) begin
          n_bad++; $display("FAIL wrap_edge k=%0d: got %h/%b required %h/%b", k, obs_vec(), sec_tick, exp_vec(), (k == 2));
        end
      end
    end
    clk_1Hz = 1'b0;
    repeat (6) @(negedge clk);
    n_cmp++;
    if ({hours, minutes, seconds} !== 17'd0) begin
      n_bad++; $display("FAIL wrap_midnight: got %h required 0", {hours, minutes, seconds});
    end
  endtask

  task automatic test_set_min();
    int nh;
    apply_reset();
    repeat (3 + $urandom_range(17)) do_tick();
    do_press(1'b1, 1'b0, rhold());
    nh = int'($urandom_range(4, 1));
    repeat (nh) do_press(1'b0, 1'b1, rhold());
    do_press(1'b1, 1'b0, rhold());
    repeat (59) do_press(1'b0, 1'b1, rhold());
    do_press(1'b0, 1'b1, rhold());
    n_cmp++;
    if (obs_vec() !== exp_vec() || minutes !== 6'd0 || hours !== 5'(nh)) begin
      n_bad++; $display("FAIL min_wrap: got %h required %h", obs_vec(), exp_vec());
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      clk_1Hz = 1'b1;
      repeat (4) @(negedge clk);
      n_cmp++;
      if (blink !== 1'b1) begin
        n_bad++; $display("FAIL blink_high[%0d]: got %b required 1", i, blink);
      end
      clk_1Hz = 1'b0;
      repeat (4) @(negedge clk);
      n_cmp++;
      if (blink !== 1'b0) begin
        n_bad++; $display("FAIL blink_low[%0d]: got %b required 0", i, blink);
      end
      model_tick();
    end
    n_cmp++;
    if (obs_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL set_frozen: got %h required %h", obs_vec(), exp_vec());
    end
    repeat (NMODES - 2) do_press(1'b1, 1'b0, rhold());
    n_cmp++;
    if (obs_vec() !== exp_vec() || seconds !== 6'd0 || mode !== 3'd0) begin
      n_bad++; $display("FAIL leave_set: got %h required %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_simul_reset();
    int h;
    apply_reset();
    do_press(1'b1, 1'b0, rhold());
    repeat ($urandom_range(3, 1)) do_press(1'b0, 1'b1, rhold());
    h = m_sod / 3600;
    do_press(1'b1, 1'b1, rhold());
    n_cmp++;
    if (obs_vec() !== exp_vec() || mode !== 3'd2 || hours !== 5'(h)) begin
      n_bad++; $display("FAIL mode_wins: got %h required %h", obs_vec(), exp_vec());
    end
    repeat ($urandom_range(3, 1)) do_press(1'b0, 1'b1, rhold());
    @(negedge clk);
    clk_1Hz = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (blink !== 1'b1) begin
      n_bad++; $display("FAIL blink_before_rst: got %b required 1", blink);
    end
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if ({obs_vec(), blink} !== 33'd0) begin
      n_bad++; $display("FAIL async_reset: got %h required 0", {obs_vec(), blink});
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    clk_1Hz = 1'b0;
    repeat (D + 8) @(negedge clk);
    n_cmp++;
    if (obs_vec() !== exp_vec() || blink !== 1'b0) begin
      n_bad++; $display("FAIL after_reset: got %h required %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_run_inc();
    apply_reset();
    repeat (2 + $urandom_range(5)) do_tick();
    do_press(1'b0, 1'b1, rhold());
    n_cmp++;
    if (obs_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL run_inc: got %h required %h", obs_vec(), exp_vec());
    end
  endtask

`ifdef ALARM_EN
  task automatic test_alarm();
    apply_reset();
    repeat (4) do_press(1'b1, 1'b0, rhold());
    do_press(1'b0, 1'b1, rhold());
    do_press(1'b1, 1'b0, rhold());
    repeat (59) do_tick();
    n_cmp++;
    if (obs_vec() !== exp_vec() || alarm !== 1'b0) begin
      n_bad++; $display("FAIL alarm_before: got %h required %h", obs_vec(), exp_vec());
    end
    do_tick();
    n_cmp++;
    if (obs_vec() !== exp_vec() || alarm !== 1'b1) begin
      n_bad++; $display("FAIL alarm_rise: got %h required %h", obs_vec(), exp_vec());
    end
    do_press(1'b0, 1'b1, rhold());
    n_cmp++;
    if (obs_vec() !== exp_vec() || alarm !== 1'b0) begin
      n_bad++; $display("FAIL alarm_silence: got %h required %h", obs_vec(), exp_vec());
    end
    repeat (59) do_tick();
    n_cmp++;
    if (obs_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL alarm_quiet: got %h required %h", obs_vec(), exp_vec());
    end
    repeat (3) do_tick();
    n_cmp++;
    if (obs_vec() !== exp_vec() || alarm !== 1'b0 || minutes !== 6'd2) begin
      n_bad++; $display("FAIL alarm_after: got %h required %h", obs_vec(), exp_vec());
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_tick();
    test_debounce();
    test_wrap();
    test_set_min();
    test_simul_reset();
    test_run_inc();
`ifdef ALARM_EN
    test_alarm();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clock_time_ctrl.md
Name: clock_time_ctrl

Overview:
- Timekeeping and mode controller for the digital clock.
- Consumes the 1 Hz square wave from the clock divider and two raw push-buttons (mode, increment).
- Sequences the run and set modes and owns the hours/minutes/seconds registers that feed the display driver.
- Produces a blink qualifier so the display can flash the field being edited.

Parameters:
- DEBOUNCE_CYCLES, 1000000, number of consecutive stable cycles before a button level is accepted (20 ms at 50 MHz).
- CNT_W, 20, width of the debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  asynchronous, active-high reset.
- clk_1Hz  in  1  1 Hz square wave from the divider.
- btn_mode  in  1  raw mode button, active-high, asynchronous.
- btn_inc  in  1  raw increment button, active-high, asynchronous.
- hours  out  5  current hour, 0-23.
- minutes  out  6  current minute, 0-59.
- seconds  out  6  current second, 0-59.
- mode  out  3  0=RUN, 1=SET_HR, 2=SET_MIN, 3=SET_AHR, 4=SET_AMIN.
- blink  out  1  edit-field flash enable.
- sec_tick  out  1  one-cycle pulse per second.
- alarm_hours  out  5  alarm hour.
- alarm_minutes  out  6  alarm minute.
- alarm  out  1  alarm active.

Behaviour:
- Reset: asynchronous, active-high. All outputs and registers are 0. FSM enters RUN. Debounced button states are 0.
- Tick path: clk_1Hz passes through a 2-flop synchronizer plus one history flop. sec_tick = sync2 & ~hist, registered. A rising edge of clk_1Hz first sampled at posedge N gives sec_tick high for exactly cycle N+3.
- Buttons: each button gets a 2-flop sync and a debounce counter.
  - The counter clears whenever the synced level equals the stable level.
  - Otherwise it increments. On reaching DEBOUNCE_CYCLES-1 the stable level takes the synced level and the counter clears.
  - A press is a one-cycle pulse on a 0->1 transition of the stable level. Releases produce no pulse.
- FSM transitions on mode_press: RUN->SET_HR->SET_MIN->RUN. With ALARM_EN: SET_MIN->SET_AHR->SET_AMIN->RUN.
- RUN:
  - On sec_tick, seconds increments.
  - 59 wraps to 0 and carries to minutes. Minutes 59 wraps and carries to hours. Hours 23 wraps to 0.
  - 23:59:59 -> 00:00:00 on a single tick.
- SET states:
  - sec_tick is ignored; time is frozen.
  - inc_press adds 1 to the selected field, modulo 24 or 60, with no carry into other fields.
  - Leaving SET_MIN (or SET_AMIN) to RUN clears seconds to 0 in that same cycle.
- Simultaneous events:
  - mode_press and inc_press in the same cycle: mode wins, inc is dropped.
  - sec_tick coinciding with mode_press from SET_MIN to RUN: seconds=0 wins, and the tick is dropped.
- blink equals the synced clk_1Hz level in any SET state, and 0 in RUN. It updates the cycle after a state change.
- Reset mid-edit: returns to RUN with 00:00:00 and no pending press. A held button must be released and re-pressed, because the stable level resets to 0 and the next accepted 1 produces a pulse.
- mode never takes values outside the legal encoding.

Optional Feature:
- Macro ALARM_EN.
- Defined:
  - Adds states SET_AHR and SET_AMIN, which edit alarm_hours (mod 24) and alarm_minutes (mod 60) like the time fields.
  - alarm is high while in RUN and hours==alarm_hours and minutes==alarm_minutes, unless silenced.
  - inc_press in RUN while alarm is high sets a silence flag. The flag clears when the minutes value changes, and on reset.
- Undefined:
  - alarm_hours, alarm_minutes and alarm are tied 0. No alarm states exist.
  - inc_press in RUN is ignored.

Decomposition:
- Shared package clock_pkg holds:
  - mode encoding constants: MODE_RUN, MODE_SET_HR, MODE_SET_MIN, MODE_SET_AHR, MODE_SET_AMIN;
  - HOURS_MAX=23 and MIN_SEC_MAX=59;
  - field width constants: 5 for hours, 6 for minutes/seconds.
- Sub-module btn_debounce (sync, counter, press pulse) is instantiated twice. Tick detection stays inline.

Test Plan:
- Reset, then 3 clk_1Hz rising edges: seconds 0->3; each sec_tick pulse is 1 cycle wide, 3 cycles after the edge is sampled.
- Preload 23:59:58 via set mode, return to RUN, 2 ticks: reads 23:59:59 then 00:00:00 on the same cycle as the second tick.
- btn_inc glitches of DEBOUNCE_CYCLES-2 cycles in SET_HR: hours unchanged. A clean press held DEBOUNCE_CYCLES+5 cycles gives hours +1, exactly once.
- In SET_MIN at minutes=59, one inc press: minutes=0, hours unchanged. Mode press: RUN and seconds=0. During SET, 5 ticks leave seconds frozen and blink follows clk_1Hz.
- mode and inc presses debounced to the same cycle in SET_HR: mode becomes SET_MIN and hours is unchanged. Assert rst mid-SET_MIN: immediate 00:00:00, mode=0, blink=0.
- ALARM_EN: alarm set to 00:01, run from 00:00:59. alarm rises at 00:01:00; inc press drops it; it stays low until 00:02, then remains low.
